// File: rtl/clkmeas.sv
// Clock ratio meter: measures period and high time of a slow input in clk cycles,
// flags timeouts (stalled) and a stable ratio (locked).
module clkmeas #(
  parameter int N     = 8,
  parameter int LOCKN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_i,
  output logic [N-1:0] period_o,
  output logic [N-1:0] high_o,
  output logic         valid_o,
  output logic         stalled_o,
  output logic         locked_o
);

  localparam logic [0:0]   IDLE   = 1'b0;
  localparam logic [0:0]   MEAS   = 1'b1;
  localparam logic [N-1:0] CNT_TO = {{(N-1){1'b1}}, 1'b0};
  localparam logic [7:0]   M_MAX  = 8'(LOCKN - 1);

  logic [2:0]   sync_q;
  logic [0:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] hcnt_q, hcnt_d;
  logic [N-1:0] period_q, period_d;
  logic [N-1:0] high_q, high_d;
  logic         valid_q, valid_d;
  logic         stalled_q, stalled_d;
  logic         locked_q, locked_d;
  logic [7:0]   mcnt_q, mcnt_d;

  logic rise, fall;
  logic [N-1:0] cnt_inc;

  // sync_q[0]..[2] are the s1..s3 stages; edges are detected between s2 and s3
  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    locked_d  = locked_q;
    mcnt_d    = mcnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d  = cnt_inc;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          stalled_d = 1'b0;
          cnt_d     = '0;
          // a zero previous period marks the first measurement of a run
          if ((cnt_inc == period_q) && (period_q != '0)) begin
            mcnt_d = (mcnt_q >= M_MAX) ? M_MAX : mcnt_q + 8'd1;
          end else begin
            mcnt_d = 8'd0;
          end
          locked_d = (mcnt_d == M_MAX);
        end else if (cnt_q == CNT_TO) begin
          period_d  = '0;
          high_d    = '0;
          valid_d   = 1'b1;
          stalled_d = 1'b1;
          locked_d  = 1'b0;
          mcnt_d    = 8'd0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (fall) begin
            hcnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 3'b000;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
      locked_q  <= 1'b0;
      mcnt_q    <= 8'd0;
    end else begin
      sync_q    <= {sync_q[1:0], sig_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
      locked_q  <= locked_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign stalled_o = stalled_q;
  assign locked_o  = locked_q;

endmodule

// File: doc/clkmeas.md
# clkmeas

Clock ratio meter: measures the period and high time of a slow, free-running clock-like input `sig` in cycles of the system clock `clk`. It recovers the ratio that a divider in the clock tree produced, and reports whether that ratio is stable. It sits next to divider outputs or external clock inputs, for frequency monitoring, lock detection and stall detection. All results are registered in the `clk` domain. `sig` may be asynchronous to `clk`.

## Interface
- `n`, 8: width of measurement results; maximum reportable period is 2^n-1 cycles.
- `lockn`, 4: number of consecutive identical period measurements required to assert `locked`; range 2..255.

- `clk`  in  1  system clock; every flop is on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig`  in  1  measured signal, asynchronous; its frequency must be ≤ clk/2.
- `period`  out  n  last measured rise-to-rise interval in `clk` cycles; 0 after a timeout.
- `high`  out  n  `clk` cycles from rise to fall within the last measured period; 0 after a timeout.
- `valid`  out  1  one-cycle strobe; `period`, `high` and `stalled` were updated this cycle.
- `stalled`  out  1  set by a timeout; cleared by the next valid measurement.
- `locked`  out  1  the last `lockn` periods were identical.

## Operation
- Synchronizer: the chain s1→s2→s3 resets to 0. `rise` = s2 & ~s3. `fall` = ~s2 & s3.
- Counter `cnt` (n bits, reset 0) counts cycles since the last rise. `hcnt` (n bits, reset 0) holds the high time.
- FSM, reset state IDLE:
  - IDLE: `cnt` holds 0. On `rise`: go to MEAS with `cnt`←0. No `valid` is issued. IDLE never times out.
  - MEAS, `rise`: `period`←`cnt`+1, `high`←`hcnt`, `valid`←1, `stalled`←0, `cnt`←0.
  - MEAS, `fall`: `hcnt`←`cnt`+1. `cnt` still increments.
  - MEAS, no `rise`, `cnt` == 2^n-2: timeout. `period`←0, `high`←0, `valid`←1, `stalled`←1, go to IDLE with `cnt`←0.
  - MEAS, otherwise: `cnt`←`cnt`+1.
- Width rule: the timeout guarantees `cnt`+1 ≤ 2^n-1, so no saturation logic is needed. The valid `period` range is 2..2^n-1.
- Lock: match counter `mcnt` (reset 0).
  - On a valid measurement, if the new period equals the previous `period` and the previous `period` ≠ 0: `mcnt`←min(`mcnt`+1, `lockn`-1).
  - On a valid measurement otherwise: `mcnt`←0.
  - `locked` = (`mcnt` == `lockn`-1), registered, updated in the same cycle as `valid`.
  - A timeout forces `mcnt`←0 and `locked`←0.
- The first measurement after IDLE compares against `period` = 0, so it never counts as a match.

## Timing
- Reset values: `period` = 0, `high` = 0, `valid` = 0, `stalled` = 0, `locked` = 0, FSM = IDLE.
- Asserting `rst_n` mid-measurement clears all state immediately. The first rise after release only arms MEAS.
- Latency: `sig` is sampled high at edge k. `valid` and the new results are visible after edge k+2, a constant 3-edge pipeline. Fall latency is identical, so `high` has no skew error.
- `valid` is high for exactly one cycle per rise in MEAS, or per timeout. A rise and a timeout can never coincide, because a rise takes precedence at `cnt` == 2^n-2.
- The outputs hold their values between `valid` strobes.
- Asynchronous `sig` gives a ±1 cycle measurement jitter. A `sig` that is synchronous to `clk` gives exact values.

## Test plan
- `sig` = clk/5 from a synchronous divider (high 2 cycles), n = 8, lockn = 4 → the first rise gives no `valid`. Then `valid` strobes every 5 cycles with `period` = 5 and `high` = 2. `locked` rises on the 4th `valid`.
- `sig` = clk/2 → `period` = 2, `high` = 1, `locked` after 4 strobes.
- Synchronous `sig` with a 255-cycle period → `period` = 255, no timeout. Then stretch one period to 256 → when `cnt` = 254 with no rise, one `valid` with `period` = 0, `high` = 0, `stalled` = 1, `locked` = 0. The next two rises give one `valid` with `period` = 256-agnostic measured value and `stalled` = 0.
- Ratio switch 5→7 mid-run → the first 7-period `valid` drops `locked` in that cycle. `locked` re-asserts on the 4th consecutive `period` = 7.
- `sig` stuck low from reset for 1000 cycles → no `valid`, all outputs 0. `sig` stopping while in MEAS → exactly one timeout `valid`, then silence.
- `rst_n` pulsed low in the middle of a clk/5 stream → all outputs read 0 within the reset pulse, with no `clk` edge needed. After release, the first rise gives no `valid`, and `locked` needs 4 fresh matches.
